lea_digit_serial_adder: RTL
===========================

Name: lea_digit_serial_adder

Overview:
- Digit-serial modular adder for the LEA encryption datapath: S = (A + B) mod 2^WIDTH.
- Forward counterpart of the decryption-side ripple subtractor.
- Processes DIGIT bits per cycle, LSB digit first, with a registered carry between digits. Trades latency for area in the round function.
- Sits between the round-key XOR stage and the rotate stage; uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits added per cycle; legal values 1, 2, 4, 8, 16, 32.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operands A/B valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  augend
- b  input  WIDTH  addend
- out_valid  output  1  sum valid
- out_ready  input  1  downstream accepts sum
- sum  output  WIDTH  (a + b) mod 2^WIDTH
- cout  output  1  final carry out (see Optional Feature)

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, carry register=0, digit counter=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a and b into shift registers, clear carry to 0 (constant-zero carry-in, no external cin), clear counter, go to RUN.
  - RUN: in_ready=0. Each cycle:
    - add the low DIGIT bits of A, B and carry;
    - shift the DIGIT-bit result into the top of the sum register (sum assembles LSB-first);
    - shift A and B right by DIGIT;
    - register the digit carry-out;
    - increment the counter.
    - When the counter reaches NDIG-1 (NDIG=WIDTH/DIGIT), go to DONE on the same edge that stores the last digit.
  - DONE: out_valid=1; sum/cout stable and held. On out_valid&&out_ready, go to IDLE with out_valid=0 on the next cycle.
- Latency: exactly NDIG cycles from the accept edge to out_valid=1 (8 cycles at defaults). Throughput is one result per NDIG+2 cycles. in_ready does not reassert until the cycle after the DONE handshake; no back-to-back overlap.
- Arithmetic: unsigned, wrap mod 2^WIDTH; overflow never flagged except via cout.
- Boundaries:
  - in_valid while busy: ignored; the operand is held by the producer per handshake.
  - out_ready low: DONE holds indefinitely with outputs stable.
  - rst asserted in any state, including mid-RUN: next edge returns to reset values; the partial result is discarded.
  - DIGIT==WIDTH: NDIG=1; RUN lasts one cycle.
  - a or b changing during RUN: no effect, because operands are latched.

Optional Feature:
- Macro: LEA_ADDER_COUT_EN.
- Defined: cout is registered with the final digit carry and is valid with out_valid.
- Undefined: the carry-out register is not built and cout is tied to 0. The port is present in both builds.

Decomposition:
- Shared package lea_pkg holds:
  - LEA_WORD_W = 32;
  - the adder state enum (IDLE, RUN, DONE);
  - a localparam function computing NDIG.
- Natural sub-module: lea_digit_adder. It is a combinational DIGIT-wide ripple of full adders: inputs a_d, b_d, cin; outputs s_d, co. It mirrors the existing full-subtractor cell and is instantiated once.

Test Plan:
- Reset, then a=0x12345678, b=0x9ABCDEF0, out_ready=1 -> out_valid exactly 8 cycles after accept, sum=0xACF13568, cout=0.
- a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000; cout=1 with LEA_ADDER_COUT_EN, otherwise 0.
- Hold out_ready=0 for 5 cycles after out_valid -> sum/out_valid stable. in_valid pulses during that window are ignored (in_ready=0). Result is consumed on out_ready=1 and in_ready=1 the cycle after.
- Assert rst at RUN cycle 4 with a=0x80000000, b=0x80000000 -> next cycle IDLE, in_ready=1, out_valid=0, sum=0. Fresh a=3, b=4 -> sum=0x00000007.
- DIGIT=1 and DIGIT=32 builds, a=0xDEADBEEF, b=0x21524111 -> sum=0x00000000, cout=1; latencies 32 and 1 cycles respectively.
- Random 10k operand pairs with random out_ready stalls -> sum matches (a+b)&0xFFFFFFFF and handshake never drops or duplicates a result.

Source files
------------

// File: rtl/lea_pkg.sv
// rtl/lea_pkg.sv - shared LEA datapath constants, adder state enum and digit-count helper
package lea_pkg;

    localparam int LEA_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/lea_digit_adder.sv
// rtl/lea_digit_adder.sv - combinational DIGIT-wide ripple of full adders
module lea_digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] s_d,
    output logic             co
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
        assign c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
    end

    assign co = c[DIGIT];

endmodule

// File: rtl/lea_digit_serial_adder.sv
// rtl/lea_digit_serial_adder.sv - digit-serial (a + b) mod 2^WIDTH; LEA_ADDER_COUT_EN builds the cout register
module lea_digit_serial_adder
    import lea_pkg::*;
#(
    parameter int WIDTH = LEA_WORD_W,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    adder_state_t     state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_shift;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DIGIT-1:0] s_d;
    logic             co;
    logic             last_digit;
    logic             accept;

    lea_digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a_d (a_q[DIGIT-1:0]),
        .b_d (b_q[DIGIT-1:0]),
        .cin (carry_q),
        .s_d (s_d),
        .co  (co)
    );

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign sum        = sum_q;
    assign accept     = in_valid && in_ready;
    assign last_digit = (cnt_q == CNT_W'(NDIG - 1));
    // New digit enters at the top so the word is LSB-aligned after NDIG shifts.
    assign sum_shift  = (sum_q >> DIGIT) | (WIDTH'(s_d) << (WIDTH - DIGIT));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_digit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= 1'b0;
                cnt_q   <= '0;
            end else if (state_q == RUN) begin
                a_q     <= a_q >> DIGIT;
                b_q     <= b_q >> DIGIT;
                sum_q   <= sum_shift;
                carry_q <= co;
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end

`ifdef LEA_ADDER_COUT_EN
    logic cout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cout_q <= 1'b0;
        end else if (accept) begin
            cout_q <= 1'b0;
        end else if (state_q == RUN && last_digit) begin
            cout_q <= co;
        end
    end

    assign cout = cout_q;
`else
    assign cout = 1'b0;
`endif

endmodule
